// File: rtl/regf_pkg.sv
// Shared register-file constants and the write-arbiter state encoding.
// Imported by rr_pick and regf_wr_arbiter.
package regf_pkg;

  localparam int REGF_DATA_W   = 8;
  localparam int REGF_ADDR_W   = 3;
  localparam int REGF_NUM_REGS = 1 << REGF_ADDR_W;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Round-robin successor of a requester index in an n-wide ring.
  function automatic logic [1:0] wrap_inc(input logic [1:0] idx, input int n);
    return (int'(idx) == n - 1) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping N-1 -> 0; returns one-hot grant, its index and a found flag.
module rr_pick
  import regf_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0] req_i,
  input  logic [1:0]   ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [1:0]   idx_o,
  output logic         valid_o
);

  int cand;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = 0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr_i) + i;
      if (cand >= N) cand = cand - N;
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = 2'(cand);
        gnt_o   = N'(1) << cand;
      end
    end
  end

endmodule

// File: rtl/regf_wr_arbiter.sv
// Round-robin arbiter sharing the reg_file write port, with multi-beat lock
// and a registered write stage. Define REGF_ARB_PRIO_EN for requester-0 priority.
module regf_wr_arbiter
  import regf_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int DATA_W   = REGF_DATA_W,
  parameter int ADDR_W   = REGF_ADDR_W,
  parameter int LOCK_MAX = 4
) (
  input  logic                      clk,
  input  logic                      reset_,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_sel,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_sel,
  output logic [DATA_W-1:0]         wr_data,
  output logic [1:0]                grant_id,
  output logic                      locked
);

  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  arb_state_e         state_q, state_d;
  logic [1:0]         rr_ptr_q, rr_ptr_d;
  logic [1:0]         owner_q, owner_d;
  logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic               wr_en_q;
  logic [ADDR_W-1:0]  wr_sel_q;
  logic [DATA_W-1:0]  wr_data_q;
  logic [1:0]         grant_id_q;

  logic [NUM_REQ-1:0] pick_gnt;
  logic [1:0]         pick_idx;
  logic               pick_any;
  logic               prio_hit;
  logic [NUM_REQ-1:0] ready_c;
  logic [1:0]         win_idx;
  logic               accept;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_any)
  );

`ifdef REGF_ARB_PRIO_EN
  assign prio_hit = req_valid[0];
`else
  assign prio_hit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    ready_c    = '0;
    win_idx    = '0;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        // Requester 0 priority win leaves the rotation pointer untouched.
        if (prio_hit) begin
          ready_c = NUM_REQ'(1);
          win_idx = 2'd0;
          accept  = 1'b1;
        end else if (pick_any) begin
          ready_c  = pick_gnt;
          win_idx  = pick_idx;
          accept   = 1'b1;
          rr_ptr_d = wrap_inc(pick_idx, NUM_REQ);
        end
        if (accept && req_lock[win_idx]) begin
          state_d    = LOCKED;
          owner_d    = win_idx;
          lock_cnt_d = CNT_W'(1);
        end
      end
      LOCKED: begin
        if (lock_cnt_q != CNT_W'(LOCK_MAX)) lock_cnt_d = lock_cnt_q + CNT_W'(1);
        if (req_valid[owner_q]) begin
          ready_c[owner_q] = 1'b1;
          win_idx          = owner_q;
          accept           = 1'b1;
          if (!req_lock[owner_q]) state_d = IDLE;
        end
        // Timeout release still lets a same-cycle owner beat be written.
        if (lock_cnt_q == CNT_W'(LOCK_MAX)) state_d = IDLE;
        if (state_d == IDLE) lock_cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      lock_cnt_q <= '0;
      wr_en_q    <= 1'b0;
      wr_sel_q   <= '0;
      wr_data_q  <= '0;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      wr_en_q    <= accept;
      if (accept) begin
        wr_sel_q   <= req_sel[win_idx*ADDR_W +: ADDR_W];
        wr_data_q  <= req_data[win_idx*DATA_W +: DATA_W];
        grant_id_q <= win_idx;
      end
    end
  end

  assign req_ready = reset_ ? ready_c : '0;
  assign wr_en     = wr_en_q;
  assign wr_sel    = wr_sel_q;
  assign wr_data   = wr_data_q;
  assign grant_id  = grant_id_q;
  assign locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_regf_wr_arbiter.sv
// Directed self-checking bench for regf_wr_arbiter (default parameters).
// Expectations for the requester-0 priority scenario follow REGF_ARB_PRIO_EN.
module tb_regf_wr_arbiter;

  logic       clk;
  logic       reset_;
  logic [2:0] req_valid;
  logic [2:0] req_lock;
  logic [8:0] req_sel;
  logic [23:0] req_data;
  logic [2:0] req_ready;
  logic       wr_en;
  logic [2:0] wr_sel;
  logic [7:0] wr_data;
  logic [1:0] grant_id;
  logic       locked;

  logic [2:0] selA  [3];
  logic [7:0] dataA [3];

  int assertCount = 0;
  int failCount   = 0;

  assign req_sel  = {selA[2], selA[1], selA[0]};
  assign req_data = {dataA[2], dataA[1], dataA[0]};

  regf_wr_arbiter dut (
    .clk       (clk),
    .reset_    (reset_),
    .req_valid (req_valid),
    .req_lock  (req_lock),
    .req_sel   (req_sel),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_data   (wr_data),
    .grant_id  (grant_id),
    .locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    assertCount++;
    if (obs !== expv) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] v, input logic [2:0] lk);
    req_valid = v;
    req_lock  = lk;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Inputs already driven just after a posedge: check this cycle's grant,
  // then the registered write that results one cycle later.
  task automatic runBeat(input string tag, input logic [2:0] expReady, input logic expWrEn,
                         input logic [2:0] expSel, input logic [7:0] expData, input logic [1:0] expId);
    #3;
    checkOutput({tag, ".ready"}, 32'(req_ready), 32'(expReady));
    stepCycle();
    checkOutput({tag, ".wr_en"}, 32'(wr_en), 32'(expWrEn));
    if (expWrEn) begin
      checkOutput({tag, ".wr_sel"}, 32'(wr_sel), 32'(expSel));
      checkOutput({tag, ".wr_data"}, 32'(wr_data), 32'(expData));
      checkOutput({tag, ".grant_id"}, 32'(grant_id), 32'(expId));
    end
  endtask

  logic [2:0] prioSeq [4];

  initial begin
    reset_ = 1'b0;
    selA[0] = 3'd1; selA[1] = 3'd2; selA[2] = 3'd3;
    dataA[0] = 8'h11; dataA[1] = 8'h22; dataA[2] = 8'h33;
    applyStimulus(3'b111, 3'b000);

    // Reset with every requester valid.
    stepCycle();
    stepCycle();
    checkOutput("rst.ready", 32'(req_ready), 32'h0);
    checkOutput("rst.wr_en", 32'(wr_en), 32'h0);
    checkOutput("rst.wr_sel", 32'(wr_sel), 32'h0);
    checkOutput("rst.wr_data", 32'(wr_data), 32'h0);
    checkOutput("rst.grant_id", 32'(grant_id), 32'h0);
    checkOutput("rst.locked", 32'(locked), 32'h0);
    reset_ = 1'b1;

    // Continuous round-robin over three requesters.
    runBeat("rr0", 3'b001, 1'b1, 3'd1, 8'h11, 2'd0);
    runBeat("rr1", 3'b010, 1'b1, 3'd2, 8'h22, 2'd1);
    runBeat("rr2", 3'b100, 1'b1, 3'd3, 8'h33, 2'd2);
    runBeat("rr3", 3'b001, 1'b1, 3'd1, 8'h11, 2'd0);
    runBeat("rr4", 3'b010, 1'b1, 3'd2, 8'h22, 2'd1);
    runBeat("rr5", 3'b100, 1'b1, 3'd3, 8'h33, 2'd2);

    // Single req0 beat moves the pointer to requester 1.
    applyStimulus(3'b001, 3'b000);
    selA[0] = 3'd7; dataA[0] = 8'h77;
    runBeat("pre", 3'b001, 1'b1, 3'd7, 8'h77, 2'd0);

    // req1 holds the port for three beats while req0/req2 wait.
    applyStimulus(3'b111, 3'b010);
    selA[0] = 3'd1; dataA[0] = 8'h11;
    selA[1] = 3'd4; dataA[1] = 8'h44;
    runBeat("lk0", 3'b010, 1'b1, 3'd4, 8'h44, 2'd1);
    checkOutput("lk0.locked", 32'(locked), 32'h1);
    selA[1] = 3'd5; dataA[1] = 8'h45;
    runBeat("lk1", 3'b010, 1'b1, 3'd5, 8'h45, 2'd1);
    applyStimulus(3'b111, 3'b000);
    selA[1] = 3'd6; dataA[1] = 8'h46;
    runBeat("lk2", 3'b010, 1'b1, 3'd6, 8'h46, 2'd1);
    checkOutput("lk2.locked", 32'(locked), 32'h0);
    applyStimulus(3'b101, 3'b000);
    runBeat("lk3", 3'b100, 1'b1, 3'd3, 8'h33, 2'd2);

    // req2 locks then goes quiet; timeout releases after LOCK_MAX cycles.
    applyStimulus(3'b100, 3'b100);
    selA[2] = 3'd2; dataA[2] = 8'h5A;
    runBeat("to0", 3'b100, 1'b1, 3'd2, 8'h5A, 2'd2);
    applyStimulus(3'b001, 3'b100);
    selA[0] = 3'd0; dataA[0] = 8'h99;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("to.locked%0d", i), 32'(locked), 32'h1);
      runBeat($sformatf("to.hold%0d", i), 3'b000, 1'b0, 3'd0, 8'h00, 2'd0);
    end
    checkOutput("to.released", 32'(locked), 32'h0);
    runBeat("to.req0", 3'b001, 1'b1, 3'd0, 8'h99, 2'd0);

    // Reset while locked with an owner beat on the wire.
    applyStimulus(3'b010, 3'b010);
    selA[1] = 3'd5; dataA[1] = 8'h55;
    runBeat("rl0", 3'b010, 1'b1, 3'd5, 8'h55, 2'd1);
    checkOutput("rl0.locked", 32'(locked), 32'h1);
    selA[1] = 3'd6; dataA[1] = 8'h56;
    reset_ = 1'b0;
    runBeat("rl1", 3'b000, 1'b0, 3'd0, 8'h00, 2'd0);
    checkOutput("rl1.locked", 32'(locked), 32'h0);
    checkOutput("rl1.grant_id", 32'(grant_id), 32'h0);
    reset_ = 1'b1;
    applyStimulus(3'b011, 3'b000);
    selA[0] = 3'd1; dataA[0] = 8'h11;
    runBeat("rl2", 3'b001, 1'b1, 3'd1, 8'h11, 2'd0);

    // Fresh start, req0 and req1 both valid continuously.
    reset_ = 1'b0;
    stepCycle();
    reset_ = 1'b1;
`ifdef REGF_ARB_PRIO_EN
    prioSeq = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
    prioSeq = '{3'b001, 3'b010, 3'b001, 3'b010};
`endif
    applyStimulus(3'b011, 3'b000);
    for (int i = 0; i < 4; i++) begin
      runBeat($sformatf("pr%0d", i), prioSeq[i], 1'b1,
              (prioSeq[i] == 3'b001) ? 3'd1 : 3'd6,
              (prioSeq[i] == 3'b001) ? 8'h11 : 8'h56,
              (prioSeq[i] == 3'b001) ? 2'd0 : 2'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
